dbus_responder: RTL and testbench

- Responder end of the CPU data-bus protocol. It accepts CPU data strobes (address, write data, byte mask, write enable) and returns read data.
- It holds the CPU's data-stall line until each access completes on a backing req/ack memory port.
- Sits between the CPU's unmapped/mapped data bus and an SRAM/IO-style backend.
- Includes a per-access timeout that completes hung accesses with an error pulse, so the pipeline cannot deadlock.

---
 rtl/dbus_responder_pkg.sv | 16 +
 rtl/dbus_responder_timeout_ctr.sv | 31 +++
 rtl/dbus_responder.sv | 118 +++++++++++
 tb/tb_dbus_responder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/dbus_responder_pkg.sv
// Shared types and constants for the CPU data-bus responder and its helpers.
package dbus_responder_pkg;

    localparam int DBUS_AW = 32;
    localparam int DBUS_DW = 32;
    localparam int DBUS_MW = 4;

    localparam logic [DBUS_DW-1:0] DBUS_ERR_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } dbus_state_e;

endpackage

// File: rtl/dbus_responder_timeout_ctr.sv
// Loadable up-counter with clear/enable and a terminal-count flag; shared by bus responders.
module dbus_timeout_ctr #(
    parameter int           W    = 8,
    parameter logic [W-1:0] TERM = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         term
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (en) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign term = (count_reg == TERM);

endmodule

// File: rtl/dbus_responder.sv
// CPU data-bus responder: stalls the CPU while each access runs on a req/ack backend,
// completing hung accesses with ERR_DATA and a one-cycle bus_err pulse.
module dbus_responder
    import dbus_responder_pkg::*;
#(
    parameter int                  TIMEOUT  = 255,
    parameter logic [DBUS_DW-1:0]  ERR_DATA = DBUS_ERR_DATA
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stb,
    input  logic [DBUS_AW-1:0] addr,
    input  logic [DBUS_DW-1:0] wdata,
    input  logic [DBUS_MW-1:0] mask,
    input  logic               we,
    output logic [DBUS_DW-1:0] rdata,
    output logic               stall,
    output logic               mem_req,
    output logic               mem_we,
    output logic [DBUS_AW-1:0] mem_addr,
    output logic [DBUS_DW-1:0] mem_wdata,
    output logic [DBUS_MW-1:0] mem_mask,
    input  logic               mem_ack,
    input  logic [DBUS_DW-1:0] mem_rdata,
    output logic               bus_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    dbus_state_e        state_reg, state_next;
    logic               accept, done_ack, done_tmo, tmo_term;
    logic               mem_req_reg, mem_we_reg, bus_err_reg;
    logic [DBUS_AW-1:0] mem_addr_reg;
    logic [DBUS_DW-1:0] mem_wdata_reg, rdata_reg;
    logic [DBUS_MW-1:0] mem_mask_reg;

    dbus_timeout_ctr #(
        .W    (CW),
        .TERM (CW'(TIMEOUT - 1))
    ) u_tmo (
        .clk      (clk),
        .rst      (rst),
        .clr      (accept),
        .load     (1'b0),
        .load_val ({CW{1'b0}}),
        .en       ((state_reg == REQ) && !mem_ack),
        .term     (tmo_term)
    );

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        done_ack   = 1'b0;
        done_tmo   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (stb) begin
                    accept     = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                // An ack arriving on the terminal-count edge takes priority over the timeout.
                if (mem_ack) begin
                    done_ack   = 1'b1;
                    state_next = RESP;
                end else if (tmo_term) begin
                    done_tmo   = 1'b1;
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_mask_reg  <= '0;
            rdata_reg     <= '0;
            bus_err_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bus_err_reg <= done_tmo;
            if (accept) begin
                mem_req_reg   <= 1'b1;
                mem_we_reg    <= we;
                mem_addr_reg  <= {addr[DBUS_AW-1:2], 2'b00};
                mem_wdata_reg <= wdata;
                mem_mask_reg  <= mask;
            end
            if (done_ack || done_tmo) begin
                mem_req_reg <= 1'b0;
            end
            if (done_ack && !mem_we_reg) begin
                rdata_reg <= mem_rdata;
            end
            if (done_tmo && !mem_we_reg) begin
                rdata_reg <= ERR_DATA;
            end
        end
    end

    assign stall     = rst && (((state_reg == IDLE) && stb) || (state_reg == REQ));
    assign rdata     = rdata_reg;
    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_mask  = mem_mask_reg;
    assign bus_err   = bus_err_reg;

endmodule

// File: tb/tb_dbus_responder.sv
// Directed bench: dut_a (TIMEOUT=255) runs a vector table, dut_b (TIMEOUT=4) the timeout corners.
module tb_dbus_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stb_a = 1'b0, stb_b = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  mask = '0;
    logic        we = 1'b0;
    logic        mem_ack_a = 1'b0, mem_ack_b = 1'b0;
    logic [31:0] mem_rdata_a = '0, mem_rdata_b = '0;

    logic [31:0] rdata_a, rdata_b, mem_addr_a, mem_addr_b, mem_wdata_a, mem_wdata_b;
    logic [3:0]  mem_mask_a, mem_mask_b;
    logic        stall_a, stall_b, mem_req_a, mem_req_b, mem_we_a, mem_we_b;
    logic        bus_err_a, bus_err_b;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    dbus_responder dut_a (
        .clk(clk), .rst(rst), .stb(stb_a), .addr(addr), .wdata(wdata), .mask(mask), .we(we),
        .rdata(rdata_a), .stall(stall_a), .mem_req(mem_req_a), .mem_we(mem_we_a),
        .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_mask(mem_mask_a),
        .mem_ack(mem_ack_a), .mem_rdata(mem_rdata_a), .bus_err(bus_err_a)
    );

    dbus_responder #(.TIMEOUT(4)) dut_b (
        .clk(clk), .rst(rst), .stb(stb_b), .addr(addr), .wdata(wdata), .mask(mask), .we(we),
        .rdata(rdata_b), .stall(stall_b), .mem_req(mem_req_b), .mem_we(mem_we_b),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_mask(mem_mask_b),
        .mem_ack(mem_ack_b), .mem_rdata(mem_rdata_b), .bus_err(bus_err_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // delay = REQ cycle (1-based) in which mem_ack pulses; 0 = never ack.
    task automatic run_access(input string name, input bit sel, input bit w,
                              input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m,
                              input int delay, input logic [31:0] mrd,
                              input logic [31:0] exp_rd, input int exp_stall, input bit exp_err);
        int n_stall = 0, n_req = 0, n_bad_hold = 0;
        bit done = 1'b0;
        logic [31:0] rd = '0;
        logic err = 1'b0, req_resp = 1'b0;
        if (sel) stb_b = 1'b1; else stb_a = 1'b1;
        we = w; addr = a; wdata = wd; mask = m;
        for (int c = 0; c < 300; c++) begin
            if (delay != 0 && c == delay) begin
                if (sel) begin mem_ack_b = 1'b1; mem_rdata_b = mrd; end
                else begin mem_ack_a = 1'b1; mem_rdata_a = mrd; end
            end
            @(negedge clk);
            if (sel ? stall_b : stall_a) begin
                n_stall++;
                if (c >= 1) begin
                    if (sel ? mem_req_b : mem_req_a) n_req++;
                    if ((sel ? mem_addr_b : mem_addr_a) !== {a[31:2], 2'b00} ||
                        (sel ? mem_we_b : mem_we_a) !== w ||
                        (sel ? mem_wdata_b : mem_wdata_a) !== wd ||
                        (sel ? mem_mask_b : mem_mask_a) !== m)
                        n_bad_hold++;
                end
            end else begin
                done = 1'b1;
                rd = sel ? rdata_b : rdata_a;
                err = sel ? bus_err_b : bus_err_a;
                req_resp = sel ? mem_req_b : mem_req_a;
            end
            @(posedge clk); #1;
            mem_ack_a = 1'b0; mem_ack_b = 1'b0;
            if (done) break;
        end
        check({name, " done"}, {31'd0, done}, 32'd1);
        check({name, " stall_cycles"}, n_stall, exp_stall);
        check({name, " req_cycles"}, n_req, exp_stall - 1);
        check({name, " backend_fields_held"}, n_bad_hold, 0);
        check({name, " rdata"}, rd, exp_rd);
        check({name, " bus_err"}, {31'd0, err}, {31'd0, exp_err});
        check({name, " mem_req_dropped"}, {31'd0, req_resp}, 0);
        $display("txn %s: we=%0b addr=0x%08h stall=%0d rdata=0x%08h bus_err=%0b",
                 name, w, a, n_stall, rd, err);
    endtask

    typedef struct {
        string       name;
        bit          w;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  m;
        int          delay;
        logic [31:0] mrd;
        logic [31:0] exp_rd;
        int          exp_stall;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{"rd_ack1",   1'b0, 32'h0000_1006, 32'h0,         4'b0000, 1, 32'h1234_5678, 32'h1234_5678, 2};
        vecs[1] = '{"wr_ack5",   1'b1, 32'h0000_2000, 32'hAABB_CCDD, 4'b0011, 5, 32'hFFFF_FFFF, 32'h1234_5678, 6};
        vecs[2] = '{"rd_ack3",   1'b0, 32'h0000_3003, 32'h0,         4'b0000, 3, 32'hCAFE_F00D, 32'hCAFE_F00D, 4};
        vecs[3] = '{"wr_ack1",   1'b1, 32'h0000_4001, 32'h0102_0304, 4'b1111, 1, 32'h1111_1111, 32'hCAFE_F00D, 2};

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset stall_a", {31'd0, stall_a}, 0);
        check("reset mem_req_a", {31'd0, mem_req_a}, 0);
        check("reset mem_addr_a", mem_addr_a, 0);
        check("reset rdata_a", rdata_a, 0);
        check("reset mem_mask_b", {28'd0, mem_mask_b}, 0);
        check("reset bus_err_b", {31'd0, bus_err_b}, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Back-to-back table on dut_a: stb stays high between vectors.
        for (int i = 0; i < 4; i++)
            run_access(vecs[i].name, 1'b0, vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].m,
                       vecs[i].delay, vecs[i].mrd, vecs[i].exp_rd, vecs[i].exp_stall, 1'b0);
        stb_a = 1'b0;

        // Stray ack while idle.
        mem_ack_a = 1'b1; mem_rdata_a = 32'h0BAD_0BAD;
        @(negedge clk);
        check("stray_idle stall", {31'd0, stall_a}, 0);
        @(posedge clk); #1;
        mem_ack_a = 1'b0;
        @(negedge clk);
        check("stray_idle rdata", rdata_a, 32'hCAFE_F00D);
        check("stray_idle mem_req", {31'd0, mem_req_a}, 0);
        @(posedge clk); #1;

        // Timeout on dut_b, then a stray late ack.
        run_access("timeout", 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'b0000, 0, 32'h0,
                   32'hDEAD_BEEF, 5, 1'b1);
        stb_b = 1'b0;
        @(negedge clk);
        check("timeout bus_err_single", {31'd0, bus_err_b}, 0);
        @(posedge clk); #1;
        mem_ack_b = 1'b1; mem_rdata_b = 32'h0000_0077;
        @(negedge clk);
        check("late_ack stall", {31'd0, stall_b}, 0);
        @(posedge clk); #1;
        mem_ack_b = 1'b0;
        @(negedge clk);
        check("late_ack rdata", rdata_b, 32'hDEAD_BEEF);
        check("late_ack bus_err", {31'd0, bus_err_b}, 0);
        check("late_ack mem_req", {31'd0, mem_req_b}, 0);
        @(posedge clk); #1;

        // Ack on the terminal-count cycle wins.
        run_access("ack_on_tmo", 1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'b0000, 4, 32'h0000_0055,
                   32'h0000_0055, 5, 1'b0);
        stb_b = 1'b0;

        // Reset in the middle of REQ.
        stb_b = 1'b1; we = 1'b0; addr = 32'h0000_0500; mask = 4'b0000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("midrst mem_req_before", {31'd0, mem_req_b}, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst stall_forced", {31'd0, stall_b}, 0);
        @(posedge clk); #1;
        rst = 1'b1; stb_b = 1'b0;
        @(negedge clk);
        check("midrst mem_req_after", {31'd0, mem_req_b}, 0);
        check("midrst stall_after", {31'd0, stall_b}, 0);
        check("midrst rdata_a_cleared", rdata_a, 0);
        @(posedge clk); #1;
        run_access("after_rst", 1'b1, 1'b0, 32'h0000_0604, 32'h0, 4'b0000, 2, 32'h0000_0099,
                   32'h0000_0099, 3, 1'b0);
        stb_b = 1'b0;
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
